// File: rtl/btn_conditioner_if.sv
// Pin-side bundle for btn_conditioner: raw pad inputs plus conditioned levels, pulses and reset.
// master = board/pad side, slave = the conditioner itself.
interface btn_conditioner_if #(
  parameter int N_BTN = 8
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_q;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;
  logic             rst_out_n;

  modport master (
    output btn_in,
    input  btn_q,
    input  btn_rise,
    input  btn_fall,
    input  rst_out_n
  );

  modport slave (
    input  btn_in,
    output btn_q,
    output btn_rise,
    output btn_fall,
    output rst_out_n
  );
endinterface

// File: rtl/btn_conditioner.sv
// N-channel button front end: 2-flop synchroniser, per-channel debounce with rise/fall pulses,
// and a stretched reset retriggered by RST_BTN. Macro BTNCOND_LONGPRESS_EN: long hold retriggers instead.
module btn_conditioner #(
  parameter int N_BTN           = 8,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RST_BTN         = 0,
  parameter int RST_LEN         = 15,
  parameter int LONG_CYCLES     = 1024
) (
  input  logic              tclk,
  input  logic              nrst,
  btn_conditioner_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RST_W = $clog2(RST_LEN + 1);
  localparam logic POL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [N_BTN-1:0] IDLE_LVL = {N_BTN{POL}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_MAX  = RST_W'(RST_LEN);

  if (N_BTN < 1 || N_BTN > 16 || DEBOUNCE_CYCLES < 1 || RST_LEN < 1 ||
      LONG_CYCLES < 1 || RST_BTN < 0 || RST_BTN >= N_BTN) begin : g_param_err
    $error("btn_conditioner: parameter out of range");
  end

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [N_BTN-1:0] level_s;
  logic [N_BTN-1:0] q_r;
  logic [N_BTN-1:0] rise_r;
  logic [N_BTN-1:0] fall_r;
  logic [N_BTN-1:0] q_nxt_s;
  logic [N_BTN-1:0] rise_nxt_s;
  logic [N_BTN-1:0] fall_nxt_s;
  logic [CNT_W-1:0] cnt_r     [N_BTN];
  logic [CNT_W-1:0] cnt_nxt_s [N_BTN];

  logic             trig_s;
  logic [RST_W-1:0] rctr_r;
  logic [RST_W-1:0] rctr_nxt_s;
  logic             rst_out_r;

  // Normalised level: 1 = pressed regardless of pad polarity.
  assign level_s = sync2_r ^ IDLE_LVL;

  // Per-channel debounce: any return to the accepted level restarts the count.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      cnt_nxt_s[i]  = cnt_r[i];
      q_nxt_s[i]    = q_r[i];
      rise_nxt_s[i] = 1'b0;
      fall_nxt_s[i] = 1'b0;
      if (level_s[i] == q_r[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == CNT_LAST) begin
        cnt_nxt_s[i]  = {CNT_W{1'b0}};
        q_nxt_s[i]    = level_s[i];
        rise_nxt_s[i] = level_s[i];
        fall_nxt_s[i] = ~level_s[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Synchroniser and debounce state; sync stages reset to the released level.
  always_ff @(posedge tclk) begin
    if (!nrst) begin
      sync1_r <= IDLE_LVL;
      sync2_r <= IDLE_LVL;
      q_r     <= {N_BTN{1'b0}};
      rise_r  <= {N_BTN{1'b0}};
      fall_r  <= {N_BTN{1'b0}};
      for (int i = 0; i < N_BTN; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_r <= bus.btn_in;
      sync2_r <= sync1_r;
      q_r     <= q_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

`ifdef BTNCOND_LONGPRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_HIT = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_nxt_s;

  // Hold counter saturates at LONG_CYCLES so a continued hold fires only once.
  always_comb begin
    hold_nxt_s = hold_r;
    trig_s     = 1'b0;
    if (!q_r[RST_BTN]) begin
      hold_nxt_s = {HOLD_W{1'b0}};
    end else if (hold_r != HOLD_MAX) begin
      hold_nxt_s = hold_r + HOLD_W'(1);
      trig_s     = (hold_r == HOLD_HIT);
    end else begin
      hold_nxt_s = hold_r;
    end
  end

  // Hold counter register.
  always_ff @(posedge tclk) begin
    if (!nrst) begin
      hold_r <= {HOLD_W{1'b0}};
    end else begin
      hold_r <= hold_nxt_s;
    end
  end
`else
  assign trig_s = rise_r[RST_BTN];
`endif

  // Reset sequencer: restart on trigger, otherwise count up and saturate.
  always_comb begin
    rctr_nxt_s = rctr_r;
    if (trig_s) begin
      rctr_nxt_s = {RST_W{1'b0}};
    end else if (rctr_r != RST_MAX) begin
      rctr_nxt_s = rctr_r + RST_W'(1);
    end else begin
      rctr_nxt_s = rctr_r;
    end
  end

  // rst_out_n is registered from the next count so release lands on the RST_LEN-th edge.
  always_ff @(posedge tclk) begin
    if (!nrst) begin
      rctr_r    <= {RST_W{1'b0}};
      rst_out_r <= 1'b0;
    end else begin
      rctr_r    <= rctr_nxt_s;
      rst_out_r <= (rctr_nxt_s == RST_MAX);
    end
  end

  assign bus.btn_q     = q_r;
  assign bus.btn_rise  = rise_r;
  assign bus.btn_fall  = fall_r;
  assign bus.rst_out_n = rst_out_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: directed pin stimulus pushes expected output events,
// monitors pop and compare whenever a pulse or a rst_out_n change appears.
module tb_btn_conditioner;

  logic tclk = 1'b0;
  always #5 tclk = ~tclk;

  logic nrst;
  logic nrst_f;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  logic prev_rstn;
  logic prev_rstn_f;
  int   k;

  typedef struct {
    int         c;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] q;
    logic       rstn;
  } ev_t;

  ev_t exp_q[$];
  ev_t fexp_q[$];

  btn_conditioner_if #(.N_BTN(8)) bus ();
  btn_conditioner_if #(.N_BTN(1)) fbus ();

  btn_conditioner #(
    .N_BTN(8), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(16),
    .RST_BTN(0), .RST_LEN(15), .LONG_CYCLES(32)
  ) dut (
    .tclk(tclk), .nrst(nrst), .bus(bus)
  );

  // Short-debounce instance so a retrigger can land inside an active reset sequence.
  btn_conditioner #(
    .N_BTN(1), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(2),
    .RST_BTN(0), .RST_LEN(15), .LONG_CYCLES(32)
  ) dut_fast (
    .tclk(tclk), .nrst(nrst_f), .bus(fbus)
  );

  always @(posedge tclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [7:0] r, input logic [7:0] f,
                      input logic [7:0] q, input logic rs);
    ev_t e;
    e = '{c: c, rise: r, fall: f, q: q, rstn: rs};
    exp_q.push_back(e);
  endtask

  task automatic fpush(input int c, input logic r, input logic f, input logic q, input logic rs);
    ev_t e;
    e = '{c: c, rise: {7'd0, r}, fall: {7'd0, f}, q: {7'd0, q}, rstn: rs};
    fexp_q.push_back(e);
  endtask

  task automatic match_event(input int which, input logic [7:0] rise, input logic [7:0] fall,
                             input logic [7:0] q, input logic rstn);
    ev_t   e;
    string tag;
    int    n;
    tag = (which == 0) ? "main" : "fast";
    n   = (which == 0) ? exp_q.size() : fexp_q.size();
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected_event cycle=%0d actual rise=%0h fall=%0h q=%0h rst_out_n=%0b required no event",
               tag, cyc, rise, fall, q, rstn);
    end else begin
      if (which == 0) e = exp_q.pop_front();
      else            e = fexp_q.pop_front();
      check({tag, "_event_cycle"}, cyc, e.c);
      check({tag, "_event_rise_fall_q_rstn"}, {7'd0, rise, fall, q, rstn},
            {7'd0, e.rise, e.fall, e.q, e.rstn});
    end
  endtask

  always @(negedge tclk) begin
    if (mon_en && (bus.btn_rise != 8'h00 || bus.btn_fall != 8'h00 || bus.rst_out_n != prev_rstn))
      match_event(0, bus.btn_rise, bus.btn_fall, bus.btn_q, bus.rst_out_n);
    prev_rstn <= bus.rst_out_n;
  end

  always @(negedge tclk) begin
    if (mon_en && (fbus.btn_rise != 1'b0 || fbus.btn_fall != 1'b0 || fbus.rst_out_n != prev_rstn_f))
      match_event(1, {7'd0, fbus.btn_rise}, {7'd0, fbus.btn_fall}, {7'd0, fbus.btn_q}, fbus.rst_out_n);
    prev_rstn_f <= fbus.rst_out_n;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge tclk);
  endtask

  initial begin
    nrst        = 1'b0;
    nrst_f      = 1'b0;
    bus.btn_in  = 8'hFF;
    fbus.btn_in = 1'b1;
    wait_cyc(3);
    check("reset_btn_q", {24'd0, bus.btn_q}, 32'd0);
    check("reset_btn_rise", {24'd0, bus.btn_rise}, 32'd0);
    check("reset_btn_fall", {24'd0, bus.btn_fall}, 32'd0);
    check("reset_rst_out_n", {31'd0, bus.rst_out_n}, 32'd0);
    check("reset_fast_rst_out_n", {31'd0, fbus.rst_out_n}, 32'd0);
    mon_en = 1'b1;

    // Power-on release: rst_out_n rises 15 edges after nrst goes high.
    k = cyc;
    push(k + 15, 8'h00, 8'h00, 8'h00, 1'b1);
    fpush(k + 15, 1'b0, 1'b0, 1'b0, 1'b1);
    nrst   = 1'b1;
    nrst_f = 1'b1;
    wait_cyc(25);

    // Clean press and release on channel 3.
    k = cyc; bus.btn_in[3] = 1'b0; push(k + 18, 8'h08, 8'h00, 8'h08, 1'b1);
    wait_cyc(30);
    k = cyc; bus.btn_in[3] = 1'b1; push(k + 18, 8'h00, 8'h08, 8'h00, 1'b1);
    wait_cyc(30);

    // Channel 5 bounces every 5 cycles for 60 cycles, then settles pressed.
    for (int i = 0; i < 12; i++) begin
      bus.btn_in[5] = ~bus.btn_in[5];
      wait_cyc(5);
    end
    k = cyc; bus.btn_in[5] = 1'b0; push(k + 18, 8'h20, 8'h00, 8'h20, 1'b1);
    wait_cyc(30);
    k = cyc; bus.btn_in[5] = 1'b1; push(k + 18, 8'h00, 8'h20, 8'h00, 1'b1);
    wait_cyc(30);

    // Channel 1: a 15-cycle glitch is rejected, a 16-cycle press is accepted.
    bus.btn_in[1] = 1'b0; wait_cyc(15); bus.btn_in[1] = 1'b1;
    wait_cyc(30);
    k = cyc; bus.btn_in[1] = 1'b0; push(k + 18, 8'h02, 8'h00, 8'h02, 1'b1);
    wait_cyc(16);
    k = cyc; bus.btn_in[1] = 1'b1; push(k + 18, 8'h00, 8'h02, 8'h00, 1'b1);
    wait_cyc(30);

    // Simultaneous presses on channels 2 and 6 pulse in the same cycle.
    k = cyc; bus.btn_in[2] = 1'b0; bus.btn_in[6] = 1'b0; push(k + 18, 8'h44, 8'h00, 8'h44, 1'b1);
    wait_cyc(30);
    k = cyc; bus.btn_in[2] = 1'b1; bus.btn_in[6] = 1'b1; push(k + 18, 8'h00, 8'h44, 8'h00, 1'b1);
    wait_cyc(30);

`ifdef BTNCOND_LONGPRESS_EN
    // 20 debounced cycles of hold: no reset.
    k = cyc; bus.btn_in[0] = 1'b0; push(k + 18, 8'h01, 8'h00, 8'h01, 1'b1);
    wait_cyc(20);
    k = cyc; bus.btn_in[0] = 1'b1; push(k + 18, 8'h00, 8'h01, 8'h00, 1'b1);
    wait_cyc(60);
    // 40-cycle hold with channel 2 pressed alongside: one restart at hold count 32.
    k = cyc; bus.btn_in[0] = 1'b0; bus.btn_in[2] = 1'b0;
    push(k + 18, 8'h05, 8'h00, 8'h05, 1'b1);
    push(k + 50, 8'h00, 8'h00, 8'h05, 1'b0);
    push(k + 58, 8'h00, 8'h05, 8'h00, 1'b0);
    push(k + 65, 8'h00, 8'h00, 8'h00, 1'b1);
    wait_cyc(40);
    bus.btn_in[0] = 1'b1; bus.btn_in[2] = 1'b1;
    wait_cyc(40);
`else
    // RST_BTN press while rst_out_n is high (counter saturated) restarts the sequence.
    k = cyc; bus.btn_in[0] = 1'b0;
    push(k + 18, 8'h01, 8'h00, 8'h01, 1'b1);
    push(k + 19, 8'h00, 8'h00, 8'h01, 1'b0);
    push(k + 34, 8'h00, 8'h00, 8'h01, 1'b1);
    wait_cyc(40);
    k = cyc; bus.btn_in[0] = 1'b1; push(k + 18, 8'h00, 8'h01, 8'h00, 1'b1);
    wait_cyc(30);
`endif

    // Fast instance: re-press at sequence count 8 restarts the full 15-cycle low.
    k = cyc; fbus.btn_in = 1'b0;
    fpush(k + 4, 1'b1, 1'b0, 1'b1, 1'b1);
    fpush(k + 5, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_cyc(5);
    fbus.btn_in = 1'b1;
    fpush(k + 9, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_cyc(4);
    fbus.btn_in = 1'b0;
    fpush(k + 13, 1'b1, 1'b0, 1'b1, 1'b0);
    fpush(k + 29, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_cyc(25);
    k = cyc; fbus.btn_in = 1'b1; fpush(k + 4, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_cyc(10);

    // nrst mid-debounce on channel 4; the held button is accepted after release of nrst.
    k = cyc; bus.btn_in[4] = 1'b0;
    wait_cyc(10);
    nrst = 1'b0; push(k + 11, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_cyc(2);
    k = cyc; nrst = 1'b1;
    push(k + 15, 8'h00, 8'h00, 8'h00, 1'b1);
    push(k + 18, 8'h10, 8'h00, 8'h10, 1'b1);
    wait_cyc(25);
    k = cyc; bus.btn_in[4] = 1'b1; push(k + 18, 8'h00, 8'h10, 8'h00, 1'b1);
    wait_cyc(30);

    check("main_pending_events", exp_q.size(), 32'd0);
    check("fast_pending_events", fexp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
